// File: rtl/button_conditioner_if.sv
// Signal bundle between a raw push-button pad and its conditioner.
// The slave side is the conditioner; the master side drives the pad and consumes events.
interface button_conditioner_if;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_short;
    logic btn_long;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_short,
        input  btn_long
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_short,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop synchroniser, consecutive-sample debouncer and
// a hold-time FSM producing registered press/release/short/long pulses.
module button_conditioner #(
    parameter logic [16:0] DEBOUNCE_CYCLES = 17'd655,
    parameter logic [16:0] LONG_CYCLES     = 17'd65535
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    logic        r_s1;
    logic        r_s2;
    logic        r_stable;
    logic [16:0] r_db_cnt;
    state_t      r_state;
    logic [16:0] r_hold_cnt;
    logic        r_press;
    logic        r_release;
    logic        r_short;
    logic        r_long;

    logic        w_db_hit;
    logic        w_rise;
    logic        w_fall;

    // Acceptance is decided combinationally so the FSM pulses land in the same
    // cycle the new debounced level becomes visible.
    assign w_db_hit = (r_s2 != r_stable) && (r_db_cnt == (DEBOUNCE_CYCLES - 17'd1));
    assign w_rise   = w_db_hit && r_s2;
    assign w_fall   = w_db_hit && !r_s2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_db_cnt <= 17'd0;
        end else begin
            r_s1 <= bus.btn_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_db_cnt <= 17'd0;
            end else if (w_db_hit) begin
                r_stable <= r_s2;
                r_db_cnt <= 17'd0;
            end else begin
                r_db_cnt <= r_db_cnt + 17'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_hold_cnt <= 17'd0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state    <= PRESSED;
                        r_hold_cnt <= 17'd1;
                        r_press    <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release has priority over reaching the hold limit.
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                    end else if (r_hold_cnt == LONG_CYCLES) begin
                        r_state <= LONG_HELD;
                        r_long  <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 17'd1;
                    end
                end
                LONG_HELD: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_release <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.btn_level   = r_stable;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;
    assign bus.btn_short   = r_short;
    assign bus.btn_long    = r_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    logic rst_prev = 1'b1;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;   // {press, release, short, long}
        logic       level;
    } exp_t;

    exp_t q[$];

    button_conditioner_if bus_if ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(17'd4),
        .LONG_CYCLES    (17'd20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    function automatic void push(int c, logic [3:0] p, logic l);
        exp_t e;
        e.cyc    = c;
        e.pulses = p;
        e.level  = l;
        q.push_back(e);
    endfunction

    logic [3:0] act;
    exp_t       e_m;

    always @(negedge clk) begin
        act = {bus_if.btn_press, bus_if.btn_release, bus_if.btn_short, bus_if.btn_long};
        if (!rst_prev) begin
            checks++;
            if (act !== 4'b0000 || bus_if.btn_level !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got pulses=%b level=%b expected pulses=0000 level=0",
                         cyc, act, bus_if.btn_level);
            end
        end else if (act != 4'b0000) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got pulses=%b level=%b expected none",
                         cyc, act, bus_if.btn_level);
            end else begin
                e_m = q.pop_front();
                if (e_m.cyc != cyc || e_m.pulses !== act || e_m.level !== bus_if.btn_level) begin
                    failures++;
                    $display("FAIL event got cyc=%0d pulses=%b level=%b expected cyc=%0d pulses=%b level=%b",
                             cyc, act, bus_if.btn_level, e_m.cyc, e_m.pulses, e_m.level);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    logic [7:0] bpat;
    int         p;

    initial begin
        reset = 1'b0;
        bus_if.btn_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bus_if.btn_raw = 1'b0;
        repeat (5) @(negedge clk);

        // Clean press then short release
        bus_if.btn_raw = 1'b1;
        push(cyc + 6, 4'b1000, 1'b1);
        repeat (10) @(negedge clk);
        bus_if.btn_raw = 1'b0;
        push(cyc + 6, 4'b0110, 1'b0);
        repeat (12) @(negedge clk);

        // Bounce rejected until a clean run of four samples
        bpat = 8'b11101110;
        for (int i = 0; i < 8; i++) begin
            bus_if.btn_raw = bpat[7 - i];
            @(negedge clk);
        end
        bus_if.btn_raw = 1'b1;
        push(cyc + 6, 4'b1000, 1'b1);
        repeat (11) @(negedge clk);
        bus_if.btn_raw = 1'b0;
        push(cyc + 6, 4'b0110, 1'b0);
        repeat (12) @(negedge clk);

        // Long press: single long pulse, release without short
        bus_if.btn_raw = 1'b1;
        p = cyc + 6;
        push(p, 4'b1000, 1'b1);
        push(p + 20, 4'b0001, 1'b1);
        repeat (46) @(negedge clk);
        bus_if.btn_raw = 1'b0;
        push(cyc + 6, 4'b0100, 1'b0);
        repeat (12) @(negedge clk);

        // Debounced fall coincides with hold_cnt reaching the limit
        bus_if.btn_raw = 1'b1;
        p = cyc + 6;
        push(p, 4'b1000, 1'b1);
        repeat (20) @(negedge clk);
        bus_if.btn_raw = 1'b0;
        push(p + 20, 4'b0110, 1'b0);
        repeat (12) @(negedge clk);

        // Reset during a hold, button still pressed afterwards
        bus_if.btn_raw = 1'b1;
        p = cyc + 6;
        push(p, 4'b1000, 1'b1);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(p + 16, 4'b1000, 1'b1);
        repeat (7) @(negedge clk);
        bus_if.btn_raw = 1'b0;
        push(cyc + 6, 4'b0110, 1'b0);
        repeat (12) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got outstanding=%0d expected 0 (next cyc=%0d pulses=%b)",
                     q.size(), q[0].cyc, q[0].pulses);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
